// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types, segment patterns and decode helper for the
//               BCD 7-segment display path.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Segment order is {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] w_seg;
        w_seg = SEG_BLANK;
        case (nibble)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            default: w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential shift-add-3 converter, 8-bit binary to 3-digit BCD,
//               reconverting whenever the input differs from the last result.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_value,
    output logic [11:0] o_bcd,
    output logic        o_bcd_valid
);

    conv_state_t r_state;
    conv_state_t w_state_next;
    logic        w_start;

    logic [7:0]  r_shreg;
    logic [7:0]  r_captured;
    logic [7:0]  r_last_value;
    logic [11:0] r_scratch;
    logic [11:0] w_adj;
    logic [2:0]  r_count;
    logic        r_force;
    logic [11:0] r_bcd;
    logic        r_bcd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_force || (i_value != r_last_value)) begin
                    w_start      = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_count == 3'd7) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Per-nibble correction; nibbles never carry into each other
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg      <= '0;
            r_captured   <= '0;
            r_last_value <= '0;
            r_scratch    <= '0;
            r_count      <= '0;
            r_force      <= 1'b1;
            r_bcd        <= '0;
            r_bcd_valid  <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shreg    <= i_value;
                        r_captured <= i_value;
                        r_scratch  <= '0;
                        r_count    <= '0;
                        r_force    <= 1'b0;
                    end
                end
                SHIFT: begin
                    {r_scratch, r_shreg} <= {w_adj, r_shreg} << 1;
                    r_count              <= r_count + 3'd1;
                end
                DONE: begin
                    r_bcd        <= r_scratch;
                    r_bcd_valid  <= 1'b1;
                    r_last_value <= r_captured;
                end
                default: ;
            endcase
        end
    end

    assign o_bcd       = r_bcd;
    assign o_bcd_valid = r_bcd_valid;

endmodule
`default_nettype wire

// File: rtl/value_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : value_bcd_display
// Description : Converts the counter value to BCD and scans it onto a
//               multiplexed 3-digit 7-segment display. Define
//               LEADING_ZERO_BLANK_EN to blank leading zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
module value_bcd_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);

    logic [c_PRE_W-1:0] r_prescale;
    logic [1:0]         r_scan_idx;
    logic [3:0]         w_nibble;
    logic [6:0]         w_seg_dec;

    bin2bcd_seq u_bin2bcd (
        .clk         (clk),
        .reset       (reset),
        .i_value     (value),
        .o_bcd       (bcd),
        .o_bcd_valid (bcd_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale <= '0;
            r_scan_idx <= DIG_UNITS;
        end else if (r_prescale == c_PRE_MAX) begin
            r_prescale <= '0;
            r_scan_idx <= (r_scan_idx == DIG_HUNDREDS) ? DIG_UNITS : r_scan_idx + 2'd1;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    always_comb begin
        w_nibble = bcd[3:0];
        case (r_scan_idx)
            DIG_TENS:     w_nibble = bcd[7:4];
            DIG_HUNDREDS: w_nibble = bcd[11:8];
            default:      w_nibble = bcd[3:0];
        endcase
    end

    assign w_seg_dec = seg7_decode(w_nibble);
    assign an        = 3'b001 << r_scan_idx;

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        seg = w_seg_dec;
        if ((r_scan_idx == DIG_HUNDREDS) && (bcd[11:8] == 4'd0)) begin
            seg = SEG_BLANK;
        end else if ((r_scan_idx == DIG_TENS) && (bcd[11:4] == 8'd0)) begin
            seg = SEG_BLANK;
        end
    end
`else
    assign seg = w_seg_dec;
`endif

endmodule
`default_nettype wire

// File: doc/value_bcd_display.md
Name: value_bcd_display

Overview:
- Downstream consumer of the 8-bit free-running counter `value` bus.
- Converts the unsigned binary value to 3-digit BCD with a sequential shift-add-3 (double-dabble) FSM.
- Drives a time-multiplexed 3-digit 7-segment display (hundreds/tens/units) for board bring-up and simulation.

Parameters:
- SCAN_DIV, 4: clocks each digit stays enabled before the scanner advances. Must be ≥1. Boards use 50000.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- value  input  8  unsigned binary from counter stage, sampled only in IDLE
- bcd  output  12  {hundreds,tens,units} BCD of last converted value, registered
- bcd_valid  output  1  one-cycle pulse when bcd updates, registered
- an  output  3  one-hot digit enable, active high; bit0 = units, bit1 = tens, bit2 = hundreds
- seg  output  7  segments {g,f,e,d,c,b,a}, active high

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. All state is cleared on a clk edge with reset=1.
- Reset values:
  - bcd = 12'h000, bcd_valid = 0
  - FSM = IDLE, force flag = 1, last_value = 0
  - scan index = 0, prescaler = 0
  - an = 3'b001, seg = 7'b0111111
- Reset asserted mid-conversion aborts the conversion at that edge; the scratch result is discarded.
- Converter FSM states and transitions:
  - IDLE: at an edge where force = 1 or value != last_value, capture value into the shift register, clear the 12-bit scratch, clear force, shift count = 0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each edge, first add 3 to every scratch nibble ≥ 5, then shift {scratch, shreg} left by 1. After the 8th shift go to DONE.
  - DONE: next edge, bcd <= scratch, bcd_valid <= 1, last_value <= captured value, go to IDLE. bcd_valid is 0 in every other cycle.
- Timing:
  - Capture at edge E0; shifts at E1..E8; bcd/bcd_valid update at E9.
  - Next compare happens at E10, so the conversion period is 10 cycles.
  - A counter incrementing every cycle is re-sampled every 10 cycles.
- value changes during SHIFT/DONE are ignored until IDLE. A change then triggers a new conversion of the current value.
- Arithmetic:
  - Add-3 is per nibble, with no carry between nibbles.
  - Max result is 12'h255. The hundreds nibble never exceeds 2.
- Scanner:
  - The prescaler counts 0..SCAN_DIV-1.
  - On the wrap edge, the index advances 0→1→2→0.
  - an = 1 << index, combinational from the registered index.
  - seg = decode(nibble[index]) of the registered bcd, so the display never shows partial conversions.
  - A new bcd appears on the currently enabled digit in the cycle after the update.
- Decode table:
  - 0 = 0111111
  - 1 = 0000110
  - 2 = 1011011
  - 3 = 1001111
  - 4 = 1100110
  - 5 = 1101101
  - 6 = 1111101
  - 7 = 0000111
  - 8 = 1111111
  - 9 = 1101111
  - 10-15 = 0000000

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - seg = 0000000 while the hundreds digit is enabled and hundreds == 0.
  - seg = 0000000 while the tens digit is enabled and hundreds == 0 and tens == 0.
  - The units digit is never blanked.
  - `an` scanning is unchanged.
- Undefined: all three digits always show their decoded value, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - converter state enum {IDLE, SHIFT, DONE}
  - 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK
  - digit index constants DIG_UNITS/TENS/HUNDREDS
  - function seg7_decode(nibble)
- Sub-module bin2bcd_seq contains the FSM, shift register, scratch, bcd, bcd_valid and last_value/force logic.
- The top level keeps the prescaler, scan index and segment muxing.

Test Plan:
- Reset, value held at 0:
  - Hold reset 2 cycles, release with value=0.
  - During reset: an=001, seg=0111111, bcd=000.
  - bcd_valid pulses once 9 edges after the first edge with reset low (force flag); bcd stays 000.
- Static value 255:
  - value=255 held: bcd=12'h255 with a single bcd_valid pulse.
  - No further pulses over 50 cycles while value is static.
- Boundary values:
  - 9 → 12'h009, 99 → 12'h099, 100 → 12'h100, 128 → 12'h128.
  - Each takes exactly 10 cycles from capture to the next IDLE.
- Scanning, SCAN_DIV=4, bcd=255:
  - an is 001 for 4 cycles with seg=1101101, then 010 for 4 cycles with seg=1101101.
  - Then 100 for 4 cycles with seg=1011011, then back to 001.
- Change mid-conversion and reset mid-conversion:
  - value=10 captured, value=20 three cycles later: first pulse gives bcd=010, next pulse 10 cycles later gives bcd=020.
  - Reset asserted during SHIFT: FSM returns to IDLE, bcd=000, no pulse; reconversion follows release.
- LEADING_ZERO_BLANK_EN defined:
  - value=7: seg=0000000 on the hundreds and tens digits, units=0000111.
  - value=100: all three digits are shown.
